// File: rtl/memory_access_arbiter_if.sv
// Bundles the signals of the memory access arbiter.
// The slave modport is the arbiter's view of the bundle. The master modport is the
// view of the surrounding environment, that is, the requesters and main memory together.
// debugState exposes the arbiter FSM state so that checkers can bind to it.
interface memory_access_arbiter_if #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int DATAWIDTH_ADDR = 32
);
  // Requester side
  logic                      MEMARB_FetchReq_In;
  logic [DATAWIDTH_ADDR-1:0] MEMARB_FetchAddr_InBus;
  logic                      MEMARB_DataReq_In;
  logic                      MEMARB_DataWrite_In;
  logic [DATAWIDTH_ADDR-1:0] MEMARB_DataAddr_InBus;
  logic [DATAWIDTH_BUS-1:0]  MEMARB_DataWrData_InBus;
  logic [DATAWIDTH_BUS-1:0]  MEMARB_RdData_OutBus;
  logic                      MEMARB_FetchDone_Out;
  logic                      MEMARB_DataDone_Out;
  logic                      MEMARB_Busy_Out;
  logic                      MEMARB_Timeout_Out;
  // Memory side
  logic                      MEMARB_MemACK_In;
  logic [DATAWIDTH_BUS-1:0]  MEMARB_MemRdData_InBus;
  logic                      MEMARB_MemRD_Out;
  logic                      MEMARB_MemWR_Out;
  logic [DATAWIDTH_ADDR-1:0] MEMARB_MemAddr_OutBus;
  logic [DATAWIDTH_BUS-1:0]  MEMARB_MemWrData_OutBus;
  // FSM state: 0=IDLE, 1=ACCESS, 2=DONE
  logic [1:0]                debugState;

  modport slave (
    input  MEMARB_FetchReq_In, MEMARB_FetchAddr_InBus,
    input  MEMARB_DataReq_In, MEMARB_DataWrite_In, MEMARB_DataAddr_InBus, MEMARB_DataWrData_InBus,
    input  MEMARB_MemACK_In, MEMARB_MemRdData_InBus,
    output MEMARB_MemRD_Out, MEMARB_MemWR_Out, MEMARB_MemAddr_OutBus, MEMARB_MemWrData_OutBus,
    output MEMARB_RdData_OutBus, MEMARB_FetchDone_Out, MEMARB_DataDone_Out,
    output MEMARB_Busy_Out, MEMARB_Timeout_Out, debugState
  );

  modport master (
    output MEMARB_FetchReq_In, MEMARB_FetchAddr_InBus,
    output MEMARB_DataReq_In, MEMARB_DataWrite_In, MEMARB_DataAddr_InBus, MEMARB_DataWrData_InBus,
    output MEMARB_MemACK_In, MEMARB_MemRdData_InBus,
    input  MEMARB_MemRD_Out, MEMARB_MemWR_Out, MEMARB_MemAddr_OutBus, MEMARB_MemWrData_OutBus,
    input  MEMARB_RdData_OutBus, MEMARB_FetchDone_Out, MEMARB_DataDone_Out,
    input  MEMARB_Busy_Out, MEMARB_Timeout_Out, debugState
  );
endinterface

// File: rtl/memory_access_arbiter.sv
// Arbitrates the single main-memory port between instruction fetch and data load/store.
// The two requesters are served round-robin, and only one access is in flight at a time.
// The FSM sequence is IDLE -> ACCESS -> DONE -> IDLE. Every output comes from a register.
// Optional feature: define MEMARB_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES
// ACCESS cycles that pass without ACK.
//
// Handshake: a requester raises its level Req and holds it, together with its address
// and data, until it sees its one-cycle Done pulse. It must drop Req before the next
// IDLE sample, unless it wants another access. Toward memory, RD or WR stays high with
// a stable address and stable data until ACK is sampled high. Read data is valid in
// the ACK cycle.
module memory_access_arbiter #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int DATAWIDTH_ADDR = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                    MEMARB_CLOCK_50,
  input logic                    MEMARB_ResetInHigh_In,
  memory_access_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arbState_t;

  arbState_t                 state, stateNext;
  logic                      memRd, memRdNext;
  logic                      memWr, memWrNext;
  logic [DATAWIDTH_ADDR-1:0] memAddr, memAddrNext;
  logic [DATAWIDTH_BUS-1:0]  memWrData, memWrDataNext;
  logic [DATAWIDTH_BUS-1:0]  rdData, rdDataNext;
  logic                      fetchDone, fetchDoneNext;
  logic                      dataDone, dataDoneNext;
  logic                      busy, busyNext;
  logic                      timeout, timeoutNext;
  // The granted requester, which is the one the current access belongs to
  logic                      grantData, grantDataNext;
  // The requester granted most recently. It loses the next tie.
  logic                      lastGrantData, lastGrantDataNext;
  logic                      pickFetch, pickData;

  // A zero or negative abort threshold has no meaning
  if (TIMEOUT_CYCLES < 1) begin : gTimeoutParamCheck
    $error("memory_access_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEMARB_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] toCnt, toCntNext;
`endif

  // Round-robin pick: a lone requester wins. On a tie, the one not granted last wins.
  always_comb begin
    pickFetch = bus.MEMARB_FetchReq_In && (!bus.MEMARB_DataReq_In || lastGrantData);
    pickData  = bus.MEMARB_DataReq_In && (!bus.MEMARB_FetchReq_In || !lastGrantData);
  end

  // Next-state and next-output logic for the FSM
  always_comb begin
    stateNext         = state;
    memRdNext         = memRd;
    memWrNext         = memWr;
    memAddrNext       = memAddr;
    memWrDataNext     = memWrData;
    rdDataNext        = rdData;
    fetchDoneNext     = 1'b0;
    dataDoneNext      = 1'b0;
    timeoutNext       = 1'b0;
    grantDataNext     = grantData;
    lastGrantDataNext = lastGrantData;
`ifdef MEMARB_TIMEOUT_EN
    toCntNext         = toCnt;
`endif
    case (state)
      IDLE: begin
        if (pickFetch) begin
          memAddrNext       = bus.MEMARB_FetchAddr_InBus;
          memRdNext         = 1'b1;
          memWrNext         = 1'b0;
          grantDataNext     = 1'b0;
          lastGrantDataNext = 1'b0;
          stateNext         = ACCESS;
`ifdef MEMARB_TIMEOUT_EN
          toCntNext         = '0;
`endif
        end else if (pickData) begin
          memAddrNext       = bus.MEMARB_DataAddr_InBus;
          memWrDataNext     = bus.MEMARB_DataWrData_InBus;
          memRdNext         = !bus.MEMARB_DataWrite_In;
          memWrNext         = bus.MEMARB_DataWrite_In;
          grantDataNext     = 1'b1;
          lastGrantDataNext = 1'b1;
          stateNext         = ACCESS;
`ifdef MEMARB_TIMEOUT_EN
          toCntNext         = '0;
`endif
        end
      end
      ACCESS: begin
        if (bus.MEMARB_MemACK_In) begin
          // A store leaves the captured read data untouched
          if (memRd) begin
            rdDataNext = bus.MEMARB_MemRdData_InBus;
          end
          memRdNext     = 1'b0;
          memWrNext     = 1'b0;
          fetchDoneNext = !grantData;
          dataDoneNext  = grantData;
          stateNext     = DONE;
        end else begin
`ifdef MEMARB_TIMEOUT_EN
          // ACK has priority, so this path only runs when ACK is absent
          toCntNext = toCnt + CntW'(1);
          if (toCntNext == CntW'(TIMEOUT_CYCLES)) begin
            rdDataNext    = '0;
            memRdNext     = 1'b0;
            memWrNext     = 1'b0;
            fetchDoneNext = !grantData;
            dataDoneNext  = grantData;
            timeoutNext   = 1'b1;
            stateNext     = DONE;
          end
`endif
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        memRdNext = 1'b0;
        memWrNext = 1'b0;
        stateNext = IDLE;
      end
    endcase
    busyNext = (stateNext != IDLE);
  end

  // State and registered outputs. Reset aborts any access at once and issues no Done.
  always_ff @(posedge MEMARB_CLOCK_50 or posedge MEMARB_ResetInHigh_In) begin
    if (MEMARB_ResetInHigh_In) begin
      state         <= IDLE;
      memRd         <= 1'b0;
      memWr         <= 1'b0;
      memAddr       <= '0;
      memWrData     <= '0;
      rdData        <= '0;
      fetchDone     <= 1'b0;
      dataDone      <= 1'b0;
      busy          <= 1'b0;
      timeout       <= 1'b0;
      grantData     <= 1'b0;
      lastGrantData <= 1'b1;
    end else begin
      state         <= stateNext;
      memRd         <= memRdNext;
      memWr         <= memWrNext;
      memAddr       <= memAddrNext;
      memWrData     <= memWrDataNext;
      rdData        <= rdDataNext;
      fetchDone     <= fetchDoneNext;
      dataDone      <= dataDoneNext;
      busy          <= busyNext;
      timeout       <= timeoutNext;
      grantData     <= grantDataNext;
      lastGrantData <= lastGrantDataNext;
    end
  end

`ifdef MEMARB_TIMEOUT_EN
  // ACCESS-cycle counter for the abort path
  always_ff @(posedge MEMARB_CLOCK_50 or posedge MEMARB_ResetInHigh_In) begin
    if (MEMARB_ResetInHigh_In) begin
      toCnt <= '0;
    end else begin
      toCnt <= toCntNext;
    end
  end
`endif

  assign bus.MEMARB_MemRD_Out        = memRd;
  assign bus.MEMARB_MemWR_Out        = memWr;
  assign bus.MEMARB_MemAddr_OutBus   = memAddr;
  assign bus.MEMARB_MemWrData_OutBus = memWrData;
  assign bus.MEMARB_RdData_OutBus    = rdData;
  assign bus.MEMARB_FetchDone_Out    = fetchDone;
  assign bus.MEMARB_DataDone_Out     = dataDone;
  assign bus.MEMARB_Busy_Out         = busy;
  assign bus.MEMARB_Timeout_Out      = timeout;
  assign bus.debugState              = state;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter. The abort scenarios run when
// MEMARB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=4). Otherwise the long-wait scenario runs.
module tb_memory_access_arbiter;

  localparam int BusW  = 32;
  localparam int AddrW = 32;
`ifdef MEMARB_TIMEOUT_EN
  localparam int ToCycles = 4;
`else
  localparam int ToCycles = 64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checkCount = 0;
  int errorCount = 0;
  logic [BusW-1:0] expQ[$];
  logic [BusW-1:0] modelRd;
  int strobeCount;
  logic sawTimeout;

  memory_access_arbiter_if #(.DATAWIDTH_BUS(BusW), .DATAWIDTH_ADDR(AddrW)) bus();

  memory_access_arbiter #(
    .DATAWIDTH_BUS(BusW), .DATAWIDTH_ADDR(AddrW), .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .MEMARB_CLOCK_50(clk),
    .MEMARB_ResetInHigh_In(rst),
    .bus(bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run, expected end before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Step past the next rising edge; outputs are stable and inputs may change
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveIdle();
    bus.MEMARB_FetchReq_In      = 1'b0;
    bus.MEMARB_FetchAddr_InBus  = '0;
    bus.MEMARB_DataReq_In       = 1'b0;
    bus.MEMARB_DataWrite_In     = 1'b0;
    bus.MEMARB_DataAddr_InBus   = '0;
    bus.MEMARB_DataWrData_InBus = '0;
    bus.MEMARB_MemACK_In        = 1'b0;
    bus.MEMARB_MemRdData_InBus  = '0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    modelRd = '0;
    expQ.delete();
  endtask

  // Memory responder: raise ACK and record the RdData expected at Done
  task automatic giveAck(input logic [BusW-1:0] data, input bit isRead);
    bus.MEMARB_MemACK_In       = 1'b1;
    bus.MEMARB_MemRdData_InBus = data;
    if (isRead) modelRd = data;
    expQ.push_back(modelRd);
  endtask

  // Checks made in the Done cycle, with the scoreboard giving the expected RdData
  task automatic checkDone(input string tag, input bit expFd, input bit expDd, input bit expTo);
    checkEq({tag, "_fetchDone"}, bus.MEMARB_FetchDone_Out, expFd);
    checkEq({tag, "_dataDone"}, bus.MEMARB_DataDone_Out, expDd);
    checkEq({tag, "_timeout"}, bus.MEMARB_Timeout_Out, expTo);
    checkEq({tag, "_sbPending"}, expQ.size() > 0, 1);
    if (expQ.size() > 0) checkEq({tag, "_rdData"}, bus.MEMARB_RdData_OutBus, expQ.pop_front());
  endtask

  initial begin
    driveIdle();
    modelRd = '0;
    tick();
    // Reset state
    checkEq("rst_rd", bus.MEMARB_MemRD_Out, 0);
    checkEq("rst_wr", bus.MEMARB_MemWR_Out, 0);
    checkEq("rst_busy", bus.MEMARB_Busy_Out, 0);
    checkEq("rst_done", {bus.MEMARB_FetchDone_Out, bus.MEMARB_DataDone_Out}, 0);
    checkEq("rst_timeout", bus.MEMARB_Timeout_Out, 0);
    checkEq("rst_addr", bus.MEMARB_MemAddr_OutBus, 0);
    checkEq("rst_rdData", bus.MEMARB_RdData_OutBus, 0);
    doReset();

    // Test 1: fetch only, ACK in the first ACCESS cycle
    bus.MEMARB_FetchReq_In     = 1'b1;
    bus.MEMARB_FetchAddr_InBus = 32'h100;
    tick();
    checkEq("t1_rd", bus.MEMARB_MemRD_Out, 1);
    checkEq("t1_wr", bus.MEMARB_MemWR_Out, 0);
    checkEq("t1_addr", bus.MEMARB_MemAddr_OutBus, 32'h100);
    checkEq("t1_busy", bus.MEMARB_Busy_Out, 1);
    checkEq("t1_earlyDone", bus.MEMARB_FetchDone_Out, 0);
    giveAck(32'hDEADBEEF, 1);
    tick();
    checkEq("t1_rdOff", bus.MEMARB_MemRD_Out, 0);
    checkDone("t1", 1, 0, 0);
    bus.MEMARB_MemACK_In = 1'b0;
    bus.MEMARB_FetchReq_In = 1'b0;
    tick();
    checkEq("t1_pulse", bus.MEMARB_FetchDone_Out, 0);
    checkEq("t1_idle", bus.MEMARB_Busy_Out, 0);

    // Test 2: store, ACK after 3 cycles; input changes after grant are ignored
    bus.MEMARB_DataReq_In       = 1'b1;
    bus.MEMARB_DataWrite_In     = 1'b1;
    bus.MEMARB_DataAddr_InBus   = 32'h40;
    bus.MEMARB_DataWrData_InBus = 32'h12345678;
    tick();
    checkEq("t2_wr1", bus.MEMARB_MemWR_Out, 1);
    checkEq("t2_rd1", bus.MEMARB_MemRD_Out, 0);
    checkEq("t2_addr1", bus.MEMARB_MemAddr_OutBus, 32'h40);
    checkEq("t2_wdata1", bus.MEMARB_MemWrData_OutBus, 32'h12345678);
    bus.MEMARB_DataAddr_InBus   = 32'hFFC;
    bus.MEMARB_DataWrData_InBus = 32'hAAAA5555;
    bus.MEMARB_DataWrite_In     = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      tick();
      checkEq("t2_wrHeld", bus.MEMARB_MemWR_Out, 1);
      checkEq("t2_addrHeld", bus.MEMARB_MemAddr_OutBus, 32'h40);
      checkEq("t2_wdataHeld", bus.MEMARB_MemWrData_OutBus, 32'h12345678);
    end
    giveAck(32'hCAFEF00D, 0);
    tick();
    checkEq("t2_wrOff", bus.MEMARB_MemWR_Out, 0);
    checkDone("t2", 0, 1, 0);
    bus.MEMARB_MemACK_In = 1'b0;
    bus.MEMARB_DataReq_In = 1'b0;
    tick();
    checkEq("t2_idle", bus.MEMARB_Busy_Out, 0);
    // A stray ACK while IDLE has no effect
    bus.MEMARB_MemACK_In = 1'b1;
    bus.MEMARB_MemRdData_InBus = 32'h11111111;
    tick();
    bus.MEMARB_MemACK_In = 1'b0;
    checkEq("idleAck_busy", bus.MEMARB_Busy_Out, 0);
    checkEq("idleAck_done", {bus.MEMARB_FetchDone_Out, bus.MEMARB_DataDone_Out}, 0);
    checkEq("idleAck_rdData", bus.MEMARB_RdData_OutBus, 32'hDEADBEEF);

    // Test 3: both requests held after reset; expected grants fetch, data, fetch
    doReset();
    bus.MEMARB_FetchReq_In     = 1'b1;
    bus.MEMARB_FetchAddr_InBus = 32'h200;
    bus.MEMARB_DataReq_In      = 1'b1;
    bus.MEMARB_DataWrite_In    = 1'b0;
    bus.MEMARB_DataAddr_InBus  = 32'h300;
    for (int g = 0; g < 3; g++) begin
      tick();
      checkEq("t3_rd", bus.MEMARB_MemRD_Out, 1);
      checkEq("t3_addr", bus.MEMARB_MemAddr_OutBus, (g == 1) ? 32'h300 : 32'h200);
      giveAck(32'hA0000000 + 32'(g), 1);
      tick();
      checkDone("t3", g != 1, g == 1, 0);
      bus.MEMARB_MemACK_In = 1'b0;
      tick();
      checkEq("t3_gap", bus.MEMARB_Busy_Out, 0);
    end
    bus.MEMARB_FetchReq_In = 1'b0;
    bus.MEMARB_DataReq_In  = 1'b0;
    tick();

    // Test 4: reset in the second ACCESS cycle
    bus.MEMARB_FetchReq_In     = 1'b1;
    bus.MEMARB_FetchAddr_InBus = 32'h500;
    tick();
    checkEq("t4_rd1", bus.MEMARB_MemRD_Out, 1);
    tick();
    checkEq("t4_rd2", bus.MEMARB_MemRD_Out, 1);
    rst = 1'b1;
    bus.MEMARB_FetchReq_In = 1'b0;
    tick();
    checkEq("t4_rdAbort", bus.MEMARB_MemRD_Out, 0);
    checkEq("t4_wrAbort", bus.MEMARB_MemWR_Out, 0);
    checkEq("t4_busyAbort", bus.MEMARB_Busy_Out, 0);
    checkEq("t4_noDone", {bus.MEMARB_FetchDone_Out, bus.MEMARB_DataDone_Out}, 0);
    rst = 1'b0;
    tick();
    checkEq("t4_noDoneAfter", {bus.MEMARB_FetchDone_Out, bus.MEMARB_DataDone_Out}, 0);
    checkEq("t4_rdDataClr", bus.MEMARB_RdData_OutBus, 0);
    modelRd = '0;
    expQ.delete();

`ifdef MEMARB_TIMEOUT_EN
    // Test 5a: ACK in the same cycle the count would expire; ACK wins
    bus.MEMARB_DataReq_In     = 1'b1;
    bus.MEMARB_DataWrite_In   = 1'b0;
    bus.MEMARB_DataAddr_InBus = 32'h80;
    tick();
    for (int i = 1; i <= 3; i++) tick();
    checkEq("t5a_rdHeld", bus.MEMARB_MemRD_Out, 1);
    giveAck(32'h77777777, 1);
    tick();
    checkDone("t5a", 0, 1, 0);
    bus.MEMARB_MemACK_In = 1'b0;
    bus.MEMARB_DataReq_In = 1'b0;
    tick();
    // Test 5b: no ACK; abort after 4 strobe cycles
    bus.MEMARB_DataReq_In = 1'b1;
    tick();
    strobeCount = 0;
    for (int i = 1; i <= 4; i++) begin
      if (bus.MEMARB_MemRD_Out) strobeCount++;
      tick();
    end
    checkEq("t5b_strobeCycles", strobeCount, 4);
    checkEq("t5b_rdOff", bus.MEMARB_MemRD_Out, 0);
    modelRd = '0;
    expQ.push_back(modelRd);
    checkDone("t5b", 0, 1, 1);
    bus.MEMARB_DataReq_In = 1'b0;
    tick();
    checkEq("t5b_pulse", bus.MEMARB_Timeout_Out, 0);
    checkEq("t5b_idle", bus.MEMARB_Busy_Out, 0);
`else
    // Test 6: ACK withheld 200 cycles; request dropped mid-access is ignored
    bus.MEMARB_FetchReq_In     = 1'b1;
    bus.MEMARB_FetchAddr_InBus = 32'h600;
    tick();
    strobeCount = 0;
    sawTimeout  = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (bus.MEMARB_MemRD_Out) strobeCount++;
      if (bus.MEMARB_Timeout_Out) sawTimeout = 1'b1;
      if (i == 50) bus.MEMARB_FetchReq_In = 1'b0;
      if (i == 200) giveAck(32'h600DF00D, 1);
      tick();
    end
    checkEq("t6_strobeCycles", strobeCount, 200);
    checkEq("t6_rdOff", bus.MEMARB_MemRD_Out, 0);
    checkEq("t6_noTimeout", sawTimeout, 0);
    checkDone("t6", 1, 0, 0);
    bus.MEMARB_MemACK_In = 1'b0;
    tick();
    checkEq("t6_idle", bus.MEMARB_Busy_Out, 0);
`endif

    // Report
    checkEq("sb_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
